// File: rtl/controle_avaliacao_pkg.sv
// ============================================================================
// Module   : controle_pkg
// Brief    : Shared widths and FSM state encoding for the evaluation sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package controle_pkg;

    localparam int CHROM_W    = 453;
    localparam int IO_W       = 8;
    localparam int BEAT_W     = 8;
    localparam int N_VEC      = 2 ** IO_W;
    localparam int N_BEATS    = (CHROM_W + BEAT_W - 1) / BEAT_W;
    localparam int FIT_W      = $clog2(N_VEC * IO_W + 1);
    localparam int BEAT_CNT_W = $clog2(N_BEATS);
    localparam int HIT_W      = $clog2(IO_W + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/controle_avaliacao_contador_acertos.sv
// ============================================================================
// Module   : contador_acertos
// Brief    : Counts bit positions where observed output equals the target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_acertos
    import controle_pkg::*;
(
    input  logic [IO_W-1:0]  obs,
    input  logic [IO_W-1:0]  tgt,
    output logic [HIT_W-1:0] hits
);

    logic [IO_W-1:0] w_match;

    assign w_match = ~(obs ^ tgt);

    always_comb begin
        hits = '0;
        for (int i = 0; i < IO_W; i++) begin
            hits = hits + HIT_W'(w_match[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/controle_avaliacao.sv
// ============================================================================
// Module   : controle_avaliacao
// Brief    : Loads a chromosome serially, sweeps all phenotype input vectors
//            and accumulates the bit-match fitness against a target ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_avaliacao
    import controle_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               load_valid,
    input  logic [BEAT_W-1:0]  load_data,
    output logic               load_ready,
    output logic [CHROM_W-1:0] cromossomo,
    output logic [IO_W-1:0]    chrom_in,
    input  logic [IO_W-1:0]    chrom_out,
    output logic [IO_W-1:0]    tgt_addr,
    input  logic [IO_W-1:0]    tgt_data,
    output logic               busy,
    output logic               done,
    output logic [FIT_W-1:0]   fitness
);

    state_t                r_state;
    logic [BEAT_CNT_W-1:0] r_beat;
    logic [IO_W-1:0]       r_obs;
    logic                  r_obs_valid;
    logic [HIT_W-1:0]      w_hits;
    logic                  w_last_beat;

    // r_obs lines up with tgt_data: both reflect the vector issued one cycle ago
    contador_acertos u_contador_acertos (
        .obs  (r_obs),
        .tgt  (tgt_data),
        .hits (w_hits)
    );

    assign w_last_beat = (r_beat == BEAT_CNT_W'(N_BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_obs       <= '0;
            r_obs_valid <= 1'b0;
            cromossomo  <= '0;
            chrom_in    <= '0;
            tgt_addr    <= '0;
            fitness     <= '0;
            load_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            r_obs       <= chrom_out;
            r_obs_valid <= (r_state == EVAL);

            if (r_obs_valid) begin
                fitness <= fitness + FIT_W'(w_hits);
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_beat     <= '0;
                        fitness    <= '0;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                LOAD: begin
                    if (load_valid) begin
                        // Final beat is partial; bits past CHROM_W-1 have no destination
                        for (int b = 0; b < CHROM_W; b++) begin
                            if (r_beat == BEAT_CNT_W'(b / BEAT_W)) begin
                                cromossomo[b] <= load_data[b % BEAT_W];
                            end
                        end
                        if (w_last_beat) begin
                            r_state    <= EVAL;
                            load_ready <= 1'b0;
                            chrom_in   <= '0;
                            tgt_addr   <= '0;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end

                EVAL: begin
                    chrom_in <= chrom_in + 1'b1;
                    tgt_addr <= tgt_addr + 1'b1;
                    if (chrom_in == IO_W'(N_VEC - 1)) begin
                        r_state <= DRAIN;
                    end
                end

                DRAIN: begin
                    r_state <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end

                default: begin
                    r_state    <= IDLE;
                    load_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_controle_avaliacao.sv
// ============================================================================
// Module   : tb_controle_avaliacao
// Brief    : Self-checking bench with identity phenotype and a synchronous
//            target ROM whose contents are selected per scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_avaliacao;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         load_valid;
    logic [7:0]   load_data;
    logic         load_ready;
    logic [452:0] cromossomo;
    logic [7:0]   chrom_in;
    logic [7:0]   chrom_out;
    logic [7:0]   tgt_addr;
    logic [7:0]   tgt_data = 8'h00;
    logic         busy;
    logic         done;
    logic [11:0]  fitness;

    int           errors = 0;
    int           checks = 0;
    int           cyc    = 0;
    int           rom_mode = 0;
    logic [7:0]   beat_val [57];
    int           exp_q [$];

    controle_avaliacao dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .cromossomo (cromossomo),
        .chrom_in   (chrom_in),
        .chrom_out  (chrom_out),
        .tgt_addr   (tgt_addr),
        .tgt_data   (tgt_data),
        .busy       (busy),
        .done       (done),
        .fitness    (fitness)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Identity phenotype
    assign chrom_out = chrom_in;

    function automatic logic [7:0] tgt_fn(input logic [7:0] a, input int mode);
        case (mode)
            1:       return ~a;
            2:       return a ^ 8'h01;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) tgt_data <= tgt_fn(tgt_addr, rom_mode);

    function automatic int model_fitness(input int mode);
        int s = 0;
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            logic [7:0] m;
            av = 8'(a);
            m  = ~(av ^ tgt_fn(av, mode));
            s += $countones(m);
        end
        return s;
    endfunction

    function automatic logic [452:0] model_chrom();
        logic [455:0] pad;
        pad = '0;
        for (int k = 0; k < 57; k++) pad[8*k +: 8] = beat_val[k];
        return pad[452:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int mode);
        rom_mode = mode;
        exp_q.push_back(model_fitness(mode));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams the 57 beats; returns the cycle index of the last handshake
    task automatic do_load(input bit gaps, input bit poke, output int t_last, output int nhs);
        int  k     = 0;
        int  guard = 0;
        bit  tog   = 1'b0;
        bit  hs;
        t_last = 0;
        while (k < 57 && guard < 400) begin
            tog        = ~tog;
            load_valid = !(gaps && !tog);
            load_data  = beat_val[k];
            start      = poke && (guard == 20);
            hs         = load_valid && load_ready;
            if (hs) t_last = cyc;
            tick();
            guard++;
            if (hs) k++;
        end
        load_valid = 1'b0;
        start      = 1'b0;
        nhs        = k;
        checks++;
        if (k != 57) begin
            errors++;
            $display("FAIL load_handshakes: got %0d required 57", k);
        end
    endtask

    task automatic wait_done(input int t_last, input bit poke, input string name);
        int n = 0;
        int expf;
        while (done !== 1'b1 && n < 400) begin
            if (cyc == t_last + 101) begin
                checks++;
                if (chrom_in !== 8'd100 || tgt_addr !== 8'd100 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_eval_v100: chrom_in=%0d tgt_addr=%0d busy=%0b required 100 100 1",
                             name, chrom_in, tgt_addr, busy);
                end
            end
            start = poke && (n == 30);
            tick();
            n++;
        end
        start = 1'b0;
        expf  = exp_q.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: done never asserted", name);
        end else begin
            if (cyc != t_last + 258) begin
                errors++;
                $display("FAIL %s_done_latency: got %0d cycles required 258", name, cyc - t_last);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy_at_done: got %0b required 0", name, busy);
            end
            checks++;
            if (fitness !== 12'(expf)) begin
                errors++;
                $display("FAIL %s_fitness: got %0d required %0d", name, fitness, expf);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (cromossomo !== '0 || chrom_in !== 8'h00 || tgt_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: crom_lsb=%0h chrom_in=%0h tgt_addr=%0h required 0 0 0",
                     cromossomo[31:0], chrom_in, tgt_addr);
        end
        checks++;
        if (fitness !== 12'd0 || load_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: fitness=%0d load_ready=%0b busy=%0b done=%0b required 0 0 0 0",
                     fitness, load_ready, busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%0b load_ready=%0b required 0 0", busy, load_ready);
        end
    endtask

    task automatic run_eval(input int mode, input bit gaps, input bit poke, input string name);
        int t_last;
        int nhs;
        do_start(mode);
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b1 || fitness !== 12'd0) begin
            errors++;
            $display("FAIL %s_enter_load: load_ready=%0b busy=%0b fitness=%0d required 1 1 0",
                     name, load_ready, busy, fitness);
        end
        do_load(gaps, poke, t_last, nhs);
        checks++;
        if (cromossomo !== model_chrom()) begin
            errors++;
            $display("FAIL %s_cromossomo: got lsb %0h msb %0h required lsb %0h msb %0h", name,
                     cromossomo[63:0], cromossomo[452:389], model_chrom() & 453'hFFFFFFFFFFFFFFFF,
                     model_chrom() >> 389);
        end
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_drop: got %0b required 0", name, load_ready);
        end
        wait_done(t_last, poke, name);
    endtask

    task automatic test_identity();
        logic [11:0] f;
        for (int k = 0; k < 57; k++) beat_val[k] = 8'hA5;
        run_eval(0, 1'b0, 1'b0, "identity");
        f = fitness;
        tick();
        checks++;
        if (done !== 1'b0 || fitness !== f || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_hold: done=%0b fitness=%0d busy=%0b required 0 %0d 0",
                     done, fitness, busy, f);
        end
    endtask

    task automatic test_target_patterns();
        run_eval(1, 1'b0, 1'b0, "invert");
        tick();
        run_eval(2, 1'b0, 1'b0, "xor1");
        tick();
    endtask

    task automatic test_gapped_load();
        for (int k = 0; k < 56; k++) beat_val[k] = 8'(k);
        beat_val[56] = 8'hFF;
        run_eval(0, 1'b1, 1'b0, "gapped");
        checks++;
        if (cromossomo[7:0] !== 8'h00 || cromossomo[15:8] !== 8'h01) begin
            errors++;
            $display("FAIL gapped_low_beats: got %0h %0h required 00 01",
                     cromossomo[7:0], cromossomo[15:8]);
        end
        checks++;
        if (cromossomo[452:448] !== 5'h1F || $isunknown(cromossomo)) begin
            errors++;
            $display("FAIL gapped_top_bits: got %0h required 1f with no X", cromossomo[452:448]);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        for (int k = 0; k < 57; k++) beat_val[k] = 8'hA5;
        run_eval(0, 1'b0, 1'b1, "start_ignored");
        tick();
    endtask

    task automatic test_reset_mid_eval();
        int t_last;
        int nhs;
        int guard = 0;
        rom_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_load(1'b0, 1'b0, t_last, nhs);
        while (chrom_in !== 8'd100 && guard < 300) begin
            tick();
            guard++;
        end
        checks++;
        if (chrom_in !== 8'd100) begin
            errors++;
            $display("FAIL abort_reach_v100: got %0d required 100", chrom_in);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || fitness !== 12'd0 || cromossomo !== '0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%0b fitness=%0d crom_lsb=%0h load_ready=%0b required 0 0 0 0",
                     busy, fitness, cromossomo[31:0], load_ready);
        end
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || cromossomo !== '0) begin
            errors++;
            $display("FAIL abort_idle: load_ready=%0b crom_lsb=%0h required 0 0",
                     load_ready, cromossomo[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        int t_last;
        int nhs;
        for (int k = 0; k < 57; k++) beat_val[k] = 8'h3C;
        run_eval(0, 1'b0, 1'b0, "b2b_first");
        rom_mode = 1;
        exp_q.push_back(model_fitness(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || fitness !== 12'd0 || load_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%0b fitness=%0d load_ready=%0b done=%0b required 1 0 1 0",
                     busy, fitness, load_ready, done);
        end
        for (int k = 0; k < 57; k++) beat_val[k] = 8'hC3;
        do_load(1'b0, 1'b0, t_last, nhs);
        checks++;
        if (cromossomo !== model_chrom()) begin
            errors++;
            $display("FAIL b2b_cromossomo: got lsb %0h required all c3 pattern", cromossomo[63:0]);
        end
        wait_done(t_last, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_identity();
        test_target_patterns();
        test_gapped_load();
        test_start_ignored();
        test_reset_mid_eval();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controle_avaliacao.md
Name: controle_avaliacao

Overview:
- Sequencer that loads a 453-bit chromosome serially into the phenotype configuration register, then sweeps every input vector through the combinational phenotype (`fenotipo`/`genetico` path).
- Compares each phenotype output against a target truth table held in an external synchronous ROM and accumulates a bit-match fitness score.
- Sits between the GA host/loader and the phenotype instance; owns that instance's `cromossomo` and `chromIn` inputs.

Parameters:
- CHROM_W, 453, chromosome width in bits (matches phenotype `cromossomo`).
- IO_W, 8, phenotype input/output width (`chromIn`/`chromOut`).
- BEAT_W, 8, serial load beat width.
- N_VEC, 256, vectors evaluated, equal to 2**IO_W.
- Derived (package): N_BEATS = ceil(CHROM_W/BEAT_W) = 57; FIT_W = clog2(N_VEC*IO_W+1) = 12.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, begin load+evaluate; accepted only in IDLE or DONE.
- load_valid, in, 1, load beat valid.
- load_data, in, BEAT_W, chromosome beat, LSB chunk first.
- load_ready, out, 1, beat accepted when load_valid && load_ready.
- cromossomo, out, CHROM_W, registered config to the phenotype.
- chrom_in, out, IO_W, registered vector to phenotype `chromIn`.
- chrom_out, in, IO_W, phenotype `chromOut` (combinational from chrom_in/cromossomo).
- tgt_addr, out, IO_W, target ROM address.
- tgt_data, in, IO_W, target ROM data, valid 1 cycle after tgt_addr.
- busy, out, 1, high in LOAD/EVAL/DRAIN.
- done, out, 1, one-cycle pulse on entry to DONE.
- fitness, out, FIT_W, matching-bit count; stable in DONE.

Behaviour:
- Reset: state=IDLE; cromossomo=0, chrom_in=0, tgt_addr=0, fitness=0, load_ready=0, busy=0, done=0. rst mid-operation aborts on the next edge with the same values; a partial chromosome is discarded.
- IDLE:
  - start -> LOAD, beat counter=0, fitness cleared.
- LOAD:
  - load_ready=1.
  - Each accepted beat k writes cromossomo[BEAT_W*k +: BEAT_W]; on the last beat (k=56) bits beyond CHROM_W-1 are discarded (load_data[7:5] ignored).
  - load_valid gaps are allowed; counter holds.
  - After beat 56 is accepted -> EVAL with vector counter v=0 and chrom_in=0.
- EVAL:
  - In the cycle counter=v: chrom_in=v and tgt_addr=v.
  - chrom_out is registered as obs. Next cycle: fitness += popcount(~(obs ^ tgt_data)).
  - v increments each cycle. After v=N_VEC-1 is issued -> DRAIN.
- DRAIN:
  - One cycle; accumulates the final vector.
  - -> DONE.
- DONE:
  - done=1 in the first DONE cycle only.
  - fitness and cromossomo are held.
  - start -> LOAD (fitness cleared, cromossomo overwritten as beats arrive).
- start is ignored in LOAD/EVAL/DRAIN.
- Latency:
  - Last beat accepted at cycle T: EVAL spans T+1..T+256, DRAIN is T+257, done is at T+258.
  - Minimum start-to-done is 1+57+256+1 cycles.
- Fitness arithmetic:
  - Unsigned, FIT_W bits, cannot overflow.
  - Max value 2048 (all 8 bits of all 256 vectors match).
  - The accumulator adds 0..8 per cycle.
- chrom_in wraps naturally from 255 to 0 on the EVAL->DRAIN edge. That value is never compared.

Decomposition:
- Package controle_pkg holds: CHROM_W, IO_W, BEAT_W, N_VEC, N_BEATS, FIT_W, and the enum state_t {IDLE, LOAD, EVAL, DRAIN, DONE}.
- Sub-module contador_acertos: combinational IO_W-bit XNOR compare plus popcount, returning a 4-bit count.
- FSM, beat counter, vector counter and accumulator stay in the top module.

Test Plan:
- Identity phenotype model (chrom_out=chrom_in), ROM tgt[a]=a, chromosome of 57 beats 0xA5 -> fitness=2048; done exactly 258 cycles after the last beat handshake; busy low from that cycle.
- Identity model, tgt[a]=~a -> fitness=0; tgt[a]=a^8'h01 -> fitness=1792.
- Load with load_valid low every other cycle, beats k=0..56 valued k, last beat 0xFF:
  - cromossomo[7:0]=0x00, cromossomo[15:8]=0x01.
  - cromossomo[452:448]=5'h1F with no X.
  - Exactly 57 handshakes; load_ready drops the cycle after the 57th.
- start pulsed during LOAD and EVAL -> no effect (fitness and timing as in test 1). rst asserted at EVAL v=100 -> next cycle IDLE, busy=0, fitness=0, cromossomo=0, load_ready=0.
- start asserted in the done cycle -> next cycle LOAD, fitness=0, busy=1. A second evaluation with tgt[a]=~a ends with fitness=0.
